hdmi_tmds_timing_encoder: RTL and testbench
===========================================

// Module: hdmi_tmds_timing_encoder
// PURPOSE
// Parametrised successor to the fixed 800x600 HDMI front end. It generates
// video timing for any mode and requests pixels ahead of time to cover the
// latency of the pixel source. It aligns DE and sync to the returned data and
// emits three DVI-1.0 TMDS 10-bit symbols per pixclk for an external serializer.
// It also adds a frame-aligned run/stop control and selectable sync polarity.
// PARAMETERS
// H_ACTIVE  800  active pixels per line
// H_FP      40   horizontal front porch, pixels
// H_SYNC    128  hsync width, pixels
// H_BP      88   horizontal back porch, pixels
// V_ACTIVE  600  active lines
// V_FP      1    vertical front porch, lines
// V_SYNC    4    vsync width, lines
// V_BP      23   vertical back porch, lines
// HS_POL    1    1 = hsync active high, 0 = active low
// VS_POL    1    1 = vsync active high, 0 = active low
// REQ_LEAD  1    cycles from pix_req to valid red/green/blue (1..8)
// CW        11   counter width; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
// pixclk       in   1   pixel clock, only clock
// reset        in   1   asynchronous, active-high
// enable       in   1   run request, level
// red          in   8   pixel data, valid REQ_LEAD cycles after pix_req
// green        in   8   pixel data, same timing as red
// blue         in   8   pixel data, same timing as red
// pix_req      out  1   registered; the pixel at pix_x/pix_y is wanted
// pix_x        out  CW  column of the requested pixel
// pix_y        out  CW  line of the requested pixel
// frame_start  out  1   one-cycle pulse with the request for pixel (0,0)
// de           out  1   data enable, aligned with the tmds_* outputs
// hsync        out  1   polarity-applied hsync, aligned with tmds_*
// vsync        out  1   polarity-applied vsync, aligned with tmds_*
// tmds_r       out  10  red channel symbol
// tmds_g       out  10  green channel symbol
// tmds_b       out  10  blue channel symbol
// BEHAVIOUR
// - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise for the V_* values.
// - States: IDLE and RUN. IDLE->RUN on the first cycle with enable=1.
// - RUN->IDLE only at cx=H_TOTAL-1, cy=V_TOTAL-1 with enable=0. Frames are never cut short.
// - Counters cx and cy:
//   - cx wraps at H_TOTAL-1; cy advances on the cx wrap and wraps at V_TOTAL-1.
//   - Both are held at 0 in IDLE.
// - Timing signals:
//   - Active area = cx<H_ACTIVE and cy<V_ACTIVE.
//   - hs_act = cx in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
//   - vs_act = cy in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
// - pix_req, pix_x and pix_y are registered from cx, cy, active area and RUN, at cycle t.
// - frame_start = pix_req && cx==0 && cy==0.
// - Alignment pipeline:
//   - de_raw, hs_act and vs_act are delayed REQ_LEAD cycles to meet the returned data.
//   - The encoder registers at the next edge, so de, hsync, vsync and tmds_* change at t+REQ_LEAD+1.
// - Sync levels: hsync = hs_act ^ ~HS_POL; vsync = vs_act ^ ~VS_POL.
// - Control codes, with CD = {vsync, hsync} on blue and 2'b00 on red and green:
//   - CD=00 -> 10'b1101010100
//   - CD=01 -> 10'b0010101011
//   - CD=10 -> 10'b0101010100
//   - CD=11 -> 10'b1010101011
// - Data encoding:
//   - Full DVI 1.0 transition-minimise plus DC-balance algorithm.
//   - Signed 5-bit running disparity per channel, cleared to 0 whenever de=0.
// - In IDLE all outputs sit at blanking: de=0, sync levels inactive, control codes.
// - Reset values, applied asynchronously and immediately, including mid-line:
//   - State IDLE, cx=cy=0, pix_req=0, pix_x=pix_y=0, frame_start=0, de=0.
//   - hsync=~HS_POL, vsync=~VS_POL, all disparities 0, all alignment-pipeline stages at blanking.
//   - tmds_r = tmds_g = 10'b1101010100.
//   - tmds_b = control code for CD={~VS_POL, ~HS_POL}.
// - enable toggling within a frame has no effect until the frame-end check.
// TESTING
// Bench params: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), REQ_LEAD=1, unless stated.
// 1 Release reset, enable=1 -> frame_start every 48 cycles; 12 pix_req per frame, 4 per line.
// 2 red=8'h00 in active -> tmds_r alternates 10'h100, 10'h3FF from the first active pixel of each line.
// 3 HS_POL=1, VS_POL=0 in blanking -> tmds_b=10'b0101010100 outside hsync, 10'b1010101011 during hsync.
// 4 REQ_LEAD=3 -> de rises exactly 4 cycles after pix_req rises; first tmds_g is the encoding of the green value presented at +3.
// 5 enable=0 at cy=1 -> frame completes through cy=5/cx=7, then IDLE with control codes and no pix_req.
// 6 Assert reset at cx=2, cy=1 -> all outputs take their reset values immediately; restart begins at (0,0).

Source files
------------

// File: rtl/hdmi_tmds_timing_encoder.sv
// Parametrised video timing generator with look-ahead pixel requests, a sync/DE
// alignment pipeline matching the pixel source latency, and three DVI 1.0 TMDS
// channel encoders feeding an external 10:1 serializer.
module hdmi_tmds_timing_encoder #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned REQ_LEAD = 1,
  parameter int unsigned CW       = 11
) (
  input  logic          pixclk,
  input  logic          reset,
  input  logic          enable,
  input  logic [7:0]    red,
  input  logic [7:0]    green,
  input  logic [7:0]    blue,
  output logic          pix_req,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          frame_start,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic [9:0]    tmds_r,
  output logic [9:0]    tmds_g,
  output logic [9:0]    tmds_b
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Thresholds carry one extra bit so a boundary equal to the total still fits.
  localparam int unsigned CWX = CW + 1;

  localparam logic [CW-1:0] HLast   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VLast   = CW'(V_TOTAL - 1);
  localparam logic [CW:0]   HActEnd = CWX'(H_ACTIVE);
  localparam logic [CW:0]   VActEnd = CWX'(V_ACTIVE);
  localparam logic [CW:0]   HsStart = CWX'(H_ACTIVE + H_FP);
  localparam logic [CW:0]   HsEnd   = CWX'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0]   VsStart = CWX'(V_ACTIVE + V_FP);
  localparam logic [CW:0]   VsEnd   = CWX'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [9:0] Ctrl00 = 10'b1101010100;
  localparam logic [9:0] Ctrl01 = 10'b0010101011;
  localparam logic [9:0] Ctrl10 = 10'b0101010100;
  localparam logic [9:0] Ctrl11 = 10'b1010101011;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // cd = {vsync, hsync}
  function automatic logic [9:0] ctrl_code(input logic [1:0] cd);
    logic [9:0] c;
    case (cd)
      2'b00:   c = Ctrl00;
      2'b01:   c = Ctrl01;
      2'b10:   c = Ctrl10;
      default: c = Ctrl11;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Returns {next_disparity[4:0], symbol[9:0]} for one active pixel.
  function automatic logic [14:0] tmds_encode(input logic [7:0] d, input logic signed [4:0] cnt);
    logic [3:0]        n1d;
    logic [3:0]        n1q;
    logic              use_xnor;
    logic [8:0]        qm;
    logic signed [4:0] n1;
    logic signed [4:0] n0;
    logic signed [4:0] cnt_n;
    logic [9:0]        q;
    n1d      = ones8(d);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    end
    qm[8] = ~use_xnor;
    n1q   = ones8(qm[7:0]);
    n1    = signed'({1'b0, n1q});
    n0    = 5'sd8 - n1;
    if ((cnt == 5'sd0) || (n1 == n0)) begin
      q     = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      cnt_n = qm[8] ? (cnt + (n1 - n0)) : (cnt + (n0 - n1));
    end else if (((cnt > 5'sd0) && (n1 > n0)) || ((cnt < 5'sd0) && (n0 > n1))) begin
      q     = {1'b1, qm[8], ~qm[7:0]};
      cnt_n = cnt + (qm[8] ? 5'sd2 : 5'sd0) + (n0 - n1);
    end else begin
      q     = {1'b0, qm[8], qm[7:0]};
      cnt_n = cnt - (qm[8] ? 5'sd0 : 5'sd2) + (n1 - n0);
    end
    return {cnt_n, q};
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cx_q, cx_d;
  logic [CW-1:0] cy_q, cy_d;
  logic [CW:0]   cx_ext, cy_ext;
  logic          run, de_raw, hs_raw, vs_raw;

  logic          pix_req_q, frame_start_q;
  logic [CW-1:0] pix_x_q, pix_y_q;
  // Bit 0 lines up with pix_req, bit REQ_LEAD with the returned pixel data.
  logic [REQ_LEAD:0] de_pipe_q, hs_pipe_q, vs_pipe_q;

  logic              de_al, hs_lvl, vs_lvl;
  logic [14:0]       enc_r, enc_g, enc_b;
  logic [9:0]        tmds_r_d, tmds_g_d, tmds_b_d;
  logic [9:0]        tmds_r_q, tmds_g_q, tmds_b_q;
  logic signed [4:0] disp_r_d, disp_g_d, disp_b_d;
  logic signed [4:0] disp_r_q, disp_g_q, disp_b_q;
  logic              de_q, hsync_q, vsync_q;

  // Run/stop control and raster counters; a stop request only takes at frame end
  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    case (state_q)
      StIdle: begin
        cx_d = '0;
        cy_d = '0;
        if (enable) state_d = StRun;
      end
      StRun: begin
        if (cx_q == HLast) begin
          cx_d = '0;
          if (cy_q == VLast) begin
            cy_d = '0;
            if (!enable) state_d = StIdle;
          end else begin
            cy_d = cy_q + 1'b1;
          end
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cx_q    <= '0;
      cy_q    <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
    end
  end

  // Raster decode at the request point; everything is blank while idle
  always_comb begin
    run    = (state_q == StRun);
    cx_ext = {1'b0, cx_q};
    cy_ext = {1'b0, cy_q};
    de_raw = run && (cx_ext < HActEnd) && (cy_ext < VActEnd);
    hs_raw = run && (cx_ext >= HsStart) && (cx_ext < HsEnd);
    vs_raw = run && (cy_ext >= VsStart) && (cy_ext < VsEnd);
  end

  // Pixel request outputs and the timing delay line towards the encoder
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      pix_req_q     <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
      de_pipe_q     <= '0;
      hs_pipe_q     <= '0;
      vs_pipe_q     <= '0;
    end else begin
      pix_req_q     <= de_raw;
      pix_x_q       <= cx_q;
      pix_y_q       <= cy_q;
      frame_start_q <= de_raw && (cx_q == '0) && (cy_q == '0);
      de_pipe_q     <= {de_pipe_q[REQ_LEAD-1:0], de_raw};
      hs_pipe_q     <= {hs_pipe_q[REQ_LEAD-1:0], hs_raw};
      vs_pipe_q     <= {vs_pipe_q[REQ_LEAD-1:0], vs_raw};
    end
  end

  // Encoder next symbols: data coding when active, control codes otherwise
  always_comb begin
    de_al  = de_pipe_q[REQ_LEAD];
    hs_lvl = hs_pipe_q[REQ_LEAD] ^ ~HS_POL;
    vs_lvl = vs_pipe_q[REQ_LEAD] ^ ~VS_POL;
    enc_r  = tmds_encode(red, disp_r_q);
    enc_g  = tmds_encode(green, disp_g_q);
    enc_b  = tmds_encode(blue, disp_b_q);
    tmds_r_d = Ctrl00;
    tmds_g_d = Ctrl00;
    tmds_b_d = ctrl_code({vs_lvl, hs_lvl});
    disp_r_d = '0;
    disp_g_d = '0;
    disp_b_d = '0;
    if (de_al) begin
      tmds_r_d = enc_r[9:0];
      tmds_g_d = enc_g[9:0];
      tmds_b_d = enc_b[9:0];
      disp_r_d = enc_r[14:10];
      disp_g_d = enc_g[14:10];
      disp_b_d = enc_b[14:10];
    end
  end

  // Encoder output and running-disparity registers
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      de_q     <= 1'b0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      tmds_r_q <= Ctrl00;
      tmds_g_q <= Ctrl00;
      tmds_b_q <= ctrl_code({~VS_POL, ~HS_POL});
      disp_r_q <= '0;
      disp_g_q <= '0;
      disp_b_q <= '0;
    end else begin
      de_q     <= de_al;
      hsync_q  <= hs_lvl;
      vsync_q  <= vs_lvl;
      tmds_r_q <= tmds_r_d;
      tmds_g_q <= tmds_g_d;
      tmds_b_q <= tmds_b_d;
      disp_r_q <= disp_r_d;
      disp_g_q <= disp_g_d;
      disp_b_q <= disp_b_d;
    end
  end

  assign pix_req     = pix_req_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = frame_start_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign tmds_r      = tmds_r_q;
  assign tmds_g      = tmds_g_q;
  assign tmds_b      = tmds_b_q;

endmodule

// File: tb/tb_hdmi_tmds_timing_encoder.sv
// Bench for hdmi_tmds_timing_encoder: two instances (REQ_LEAD=1 with active-high
// syncs, REQ_LEAD=3 with active-low vsync) driven by shared random stimulus and
// compared every cycle against a frame-position reference model.
module tb_hdmi_tmds_timing_encoder;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1, HT = HA + HF + HS + HB;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1, VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int CW = 11;

  logic          pixclk = 1'b0;
  logic          reset;
  logic          enable;
  logic [7:0]    red, green, blue;

  logic          a_req, a_fs, a_de, a_hs, a_vs;
  logic [CW-1:0] a_x, a_y;
  logic [9:0]    a_r, a_g, a_b;
  logic          b_req, b_fs, b_de, b_hs, b_vs;
  logic [CW-1:0] b_x, b_y;
  logic [9:0]    b_r, b_g, b_b;

  hdmi_tmds_timing_encoder #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(1), .CW(CW)
  ) u_dut_a (
    .pixclk(pixclk), .reset(reset), .enable(enable),
    .red(red), .green(green), .blue(blue),
    .pix_req(a_req), .pix_x(a_x), .pix_y(a_y), .frame_start(a_fs),
    .de(a_de), .hsync(a_hs), .vsync(a_vs),
    .tmds_r(a_r), .tmds_g(a_g), .tmds_b(a_b)
  );

  hdmi_tmds_timing_encoder #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b0), .REQ_LEAD(3), .CW(CW)
  ) u_dut_b (
    .pixclk(pixclk), .reset(reset), .enable(enable),
    .red(red), .green(green), .blue(blue),
    .pix_req(b_req), .pix_x(b_x), .pix_y(b_y), .frame_start(b_fs),
    .de(b_de), .hsync(b_hs), .vsync(b_vs),
    .tmds_r(b_r), .tmds_g(b_g), .tmds_b(b_b)
  );

  always #5 pixclk = ~pixclk;

  typedef struct packed {logic de; logic hs; logic vs;} tim_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state
  int         lead [2];
  bit         hpol [2];
  bit         vpol [2];
  bit         m_run;
  int         m_pos;
  tim_t       tq[$];
  bit         e_req, e_fs;
  int         e_x, e_y;
  bit         e_de [2];
  bit         e_hs [2];
  bit         e_vs [2];
  logic [9:0] e_r [2];
  logic [9:0] e_g [2];
  logic [9:0] e_b [2];
  int         disp [2][3];

  // Directed-scenario trackers
  bit cont_phase = 1'b0;
  int last_fs = -1;
  int req_cnt = 0;
  int last_req_rise = -1;
  bit prev_b_req = 1'b0;
  bit prev_b_de = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [9:0] ctrl_ref(input bit v, input bit h);
    logic [9:0] c;
    case ({v, h})
      2'b00:   c = 10'b1101010100;
      2'b01:   c = 10'b0010101011;
      2'b10:   c = 10'b0101010100;
      default: c = 10'b1010101011;
    endcase
    return c;
  endfunction

  // DVI 1.0 data symbol; disp is ones-minus-zeros of everything sent so far.
  function automatic logic [9:0] tmds_ref(input logic [7:0] d, input int disp_in);
    logic [7:0] qm;
    bit         qm8, inv, use_xnor;
    int         bal;
    use_xnor = ($countones(d) > 4) || (($countones(d) == 4) && (d[0] == 1'b0));
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i] ^ use_xnor;
    qm8 = !use_xnor;
    bal = 2 * $countones(qm) - 8;
    if (disp_in == 0 || bal == 0) inv = !qm8;
    else inv = ((disp_in > 0) == (bal > 0));
    return {inv, qm8, (inv ? ~qm : qm)};
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_pos = 0;
    tq.delete();
    for (int i = 0; i < 8; i++) tq.push_back('0);
    e_req = 1'b0; e_fs = 1'b0; e_x = 0; e_y = 0;
    for (int k = 0; k < 2; k++) begin
      e_de[k] = 1'b0;
      e_hs[k] = !hpol[k];
      e_vs[k] = !vpol[k];
      e_r[k]  = ctrl_ref(1'b0, 1'b0);
      e_g[k]  = ctrl_ref(1'b0, 1'b0);
      e_b[k]  = ctrl_ref(!vpol[k], !hpol[k]);
      for (int c = 0; c < 3; c++) disp[k][c] = 0;
    end
  endtask

  // Advance the model across one rising edge using the inputs held at that edge.
  task automatic model_edge();
    tim_t t, nt;
    int   cx, cy;
    if (reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      t = tq[lead[k]];
      e_de[k] = t.de;
      e_hs[k] = t.hs ^ !hpol[k];
      e_vs[k] = t.vs ^ !vpol[k];
      if (t.de) begin
        e_r[k] = tmds_ref(red, disp[k][0]);
        e_g[k] = tmds_ref(green, disp[k][1]);
        e_b[k] = tmds_ref(blue, disp[k][2]);
        disp[k][0] += 2 * $countones(e_r[k]) - 10;
        disp[k][1] += 2 * $countones(e_g[k]) - 10;
        disp[k][2] += 2 * $countones(e_b[k]) - 10;
      end else begin
        e_r[k] = ctrl_ref(1'b0, 1'b0);
        e_g[k] = ctrl_ref(1'b0, 1'b0);
        e_b[k] = ctrl_ref(e_vs[k], e_hs[k]);
        for (int c = 0; c < 3; c++) disp[k][c] = 0;
      end
    end
    cx = m_pos % HT;
    cy = m_pos / HT;
    nt.de = m_run && (cx < HA) && (cy < VA);
    nt.hs = m_run && (cx >= HA + HF) && (cx < HA + HF + HS);
    nt.vs = m_run && (cy >= VA + VF) && (cy < VA + VF + VS);
    tq.push_front(nt);
    void'(tq.pop_back());
    e_req = nt.de;
    e_x   = cx;
    e_y   = cy;
    e_fs  = nt.de && (m_pos == 0);
    if (!m_run) begin
      if (enable) m_run = 1'b1;
    end else if ((m_pos == FT - 1) && !enable) begin
      m_run = 1'b0;
      m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % FT;
    end
  endtask

  task automatic chk_side(input string p, input int k, input logic req, input logic [CW-1:0] x,
                          input logic [CW-1:0] y, input logic fs, input logic de_o,
                          input logic hs_o, input logic vs_o, input logic [9:0] r,
                          input logic [9:0] g, input logic [9:0] b);
    check_eq({p, ".pix_req"}, 32'(req), 32'(e_req));
    check_eq({p, ".pix_x"}, 32'(x), 32'(e_x));
    check_eq({p, ".pix_y"}, 32'(y), 32'(e_y));
    check_eq({p, ".frame_start"}, 32'(fs), 32'(e_fs));
    check_eq({p, ".de"}, 32'(de_o), 32'(e_de[k]));
    check_eq({p, ".hsync"}, 32'(hs_o), 32'(e_hs[k]));
    check_eq({p, ".vsync"}, 32'(vs_o), 32'(e_vs[k]));
    check_eq({p, ".tmds_r"}, 32'(r), 32'(e_r[k]));
    check_eq({p, ".tmds_g"}, 32'(g), 32'(e_g[k]));
    check_eq({p, ".tmds_b"}, 32'(b), 32'(e_b[k]));
  endtask

  task automatic compare_all();
    chk_side("a", 0, a_req, a_x, a_y, a_fs, a_de, a_hs, a_vs, a_r, a_g, a_b);
    chk_side("b", 1, b_req, b_x, b_y, b_fs, b_de, b_hs, b_vs, b_r, b_g, b_b);
    // Frame cadence while enable stays high: 48 cycles, 12 requests per frame
    if (cont_phase && a_fs) begin
      if (last_fs >= 0) begin
        check_eq("fs_period", 32'(cyc - last_fs), 32'(FT));
        check_eq("req_per_frame", 32'(req_cnt), 32'(HA * VA));
      end
      last_fs = cyc;
      req_cnt = 0;
    end
    if (cont_phase) req_cnt += int'(a_req);
    // Lead-3 instance: de follows the rising pix_req by exactly 4 cycles
    if (b_req && !prev_b_req) last_req_rise = cyc;
    if (b_de && !prev_b_de && last_req_rise >= 0) check_eq("b.de_lag", 32'(cyc - last_req_rise), 32'd4);
    prev_b_req = b_req;
    prev_b_de  = b_de;
  endtask

  task automatic step();
    @(posedge pixclk);
    cyc++;
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic cycle(input bit zero_red);
    step();
    red   = zero_red ? 8'h00 : 8'($urandom);
    green = 8'($urandom);
    blue  = 8'($urandom);
  endtask

  task automatic wait_run_pos(input int pos);
    int n;
    n = 0;
    while (!(m_run && m_pos == pos) && n < 4 * FT) begin
      cycle(1'b0);
      n++;
    end
    check_eq("wait_pos", 32'(m_run && m_pos == pos), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    lead[0] = 1; hpol[0] = 1'b1; vpol[0] = 1'b1;
    lead[1] = 3; hpol[1] = 1'b1; vpol[1] = 1'b0;
    reset  = 1'b1;
    enable = 1'b0;
    red = 8'h00; green = 8'h00; blue = 8'h00;
    model_reset();
    repeat (3) cycle(1'b0);
    reset = 1'b0;

    // Free-running frames with random pixels
    cont_phase = 1'b1;
    enable = 1'b1;
    repeat (4 * FT + 4) cycle(1'b0);
    // Constant zero red exercises the 100/3FF disparity alternation
    repeat (2 * FT) cycle(1'b1);
    cont_phase = 1'b0;

    // Enable toggling at random; only frame-end samples may stop the raster
    repeat (300) begin
      enable = ($urandom_range(0, 3) != 0);
      cycle(1'b0);
    end

    // Stop request during line 1: frame must complete, then idle blanking
    enable = 1'b1;
    wait_run_pos(HT);
    enable = 1'b0;
    repeat (2 * FT) cycle(1'b0);

    // Asynchronous reset at cx=2, cy=1, then restart from (0,0)
    enable = 1'b1;
    wait_run_pos(HT + 2);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    cycle(1'b0);
    cycle(1'b0);
    reset = 1'b0;
    repeat (2 * FT) cycle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
